mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 if_req_valid  input  1  instruction-fetch read request.
REQ-004 if_req_ready  output  1  fetch request accepted this cycle when high with if_req_valid.
REQ-005 if_addr  input  64  fetch address.
REQ-006 if_resp_valid  output  1  one-cycle pulse, fetch data valid.
REQ-007 if_rdata  output  64  fetch read data.
REQ-008 ls_req_valid / ls_req_ready  input / output  1 / 1  load-store request handshake.
REQ-009 ls_addr, ls_wdata  input  64 each  load-store address, store data.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_wmask  input  8  byte-lane store mask.
REQ-012 ls_resp_valid  output  1  one-cycle pulse, load data valid or store completed.
REQ-013 ls_rdata  output  64  load data; 0 for stores.
REQ-014 mem_ce, mem_we  output  1 each  memory chip-enable, write-enable.
REQ-015 mem_addr, mem_wdata  output  64 each  memory address, write data.
REQ-016 mem_wmask  output  8  memory byte mask.
REQ-017 mem_rdata  input  64  combinational memory read data, valid same cycle as mem_ce=1, mem_we=0.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-019 IDLE: request readies asserted only in IDLE, only to the arbitration winner; loser ready=0.
REQ-020 Accept (valid&&ready) SHALL capture addr/we/wdata/wmask and grant owner into registers, next state ACCESS; fetch captures we=0, wmask=0, wdata=0.
REQ-021 ACCESS: mem_ce=1 for exactly one cycle driving captured values; on mem_we=0 mem_rdata latched into response register; next state RESP.
REQ-022 RESP: owner's resp_valid=1 for one cycle with its rdata; other requester's resp_valid=0; next state IDLE.
REQ-023 Latency: accept cycle N, mem_ce cycle N+1, resp_valid cycle N+2; earliest next accept N+3.
REQ-024 Outside ACCESS: mem_ce=0, mem_we=0, mem_addr/mem_wdata/mem_wmask=0.
REQ-025 if_rdata/ls_rdata hold last value delivered to that requester until its next RESP; store response drives ls_rdata=0.
REQ-026 Store with ls_wmask=0 SHALL still issue one mem_ce cycle and a response.
REQ-027 Request inputs ignored outside IDLE; requester valid may drop before accept with no effect.
REQ-028 Requesters SHALL accept resp_valid unconditionally; no response backpressure.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, all readies/resp_valids/mem_ce/mem_we 0, all data outputs and capture registers 0, last-grant register = fetch.
REQ-030 Reset during ACCESS or RESP abandons the transaction; no response pulse after reset release.

Configuration
REQ-031 Macro MEM_ARBITER_RR_EN.
REQ-032 Defined: round-robin; on simultaneous requests grant the requester not granted last; last-grant updates on every accept; after reset fetch counts as last granted, so first contested grant goes to load-store.
REQ-033 Undefined: fixed priority, load-store always wins when both valid; no last-grant register.
REQ-034 Single requester valid SHALL be granted in IDLE in both configurations.

Verification
REQ-035 Fetch only: if_addr=0x80000000, mem_rdata=0x00000013_00100093 -> mem_ce at N+1 addr 0x80000000 we=0, if_resp_valid at N+2, if_rdata=0x0000001300100093.
REQ-036 Store: ls_addr=0x80001000, wdata=0xDEADBEEF_CAFEF00D, wmask=0x0F -> mem_ce=mem_we=1 at N+1 with those values, ls_resp_valid at N+2, ls_rdata=0.
REQ-037 Both valid continuously, no RR -> four consecutive grants all load-store, accepts at N, N+3, N+6, N+9, if_req_ready never 1.
REQ-038 Both valid continuously, RR -> grants alternate LS, IF, LS, IF starting from reset.
REQ-039 rst_n low in ACCESS of a load -> mem_ce 0 immediately, no ls_resp_valid, next request after release served normally with 2-cycle latency.
REQ-040 Back-to-back fetches -> mem_ce exactly one cycle per transaction, resp_valid never two consecutive cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load-store) single-port memory arbiter; MEM_ARBITER_RR_EN selects round-robin, else load-store priority.
// Latency: accept N, memory access N+1, response pulse N+2; next accept no earlier than N+3.
// Backpressure: ready only in IDLE to the arbitration winner; responses are never stalled.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    output logic [63:0] if_rdata,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    input  logic        ls_we,
    input  logic [7:0]  ls_wmask,
    output logic        ls_resp_valid,
    output logic [63:0] ls_rdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;     // 1 = load-store owns the transaction
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [63:0] if_rdata_q, if_rdata_d;
    logic [63:0] ls_rdata_q, ls_rdata_d;

    logic        prefer_ls;
    logic        grant_ls;
    logic        if_acc;
    logic        ls_acc;

`ifdef MEM_ARBITER_RR_EN
    logic        last_ls_q, last_ls_d;

    assign prefer_ls = !last_ls_q;

    always_comb begin
        last_ls_d = last_ls_q;
        if (if_acc || ls_acc) begin
            last_ls_d = ls_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ls_q <= 1'b0;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    assign prefer_ls = 1'b1;
`endif

    // Winner only matters on contention; a lone requester always wins.
    assign grant_ls = ls_req_valid && (!if_req_valid || prefer_ls);
    assign if_acc   = if_req_valid && if_req_ready;
    assign ls_acc   = ls_req_valid && ls_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (if_acc || ls_acc) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_ce        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 64'd0;
        mem_wdata     = 64'd0;
        mem_wmask     = 8'd0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so readies drop the instant reset asserts.
                ls_req_ready = rst_n && grant_ls;
                if_req_ready = rst_n && if_req_valid && !grant_ls;
            end
            ACCESS: begin
                mem_ce    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
            end
            RESP: begin
                if_resp_valid = !owner_q;
                ls_resp_valid = owner_q;
            end
            default: begin
                if_req_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wmask_d    = wmask_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if (state_q == IDLE && (if_acc || ls_acc)) begin
            owner_d = ls_acc;
            addr_d  = ls_acc ? ls_addr : if_addr;
            we_d    = ls_acc && ls_we;
            wdata_d = ls_acc ? ls_wdata : 64'd0;
            wmask_d = ls_acc ? ls_wmask : 8'd0;
        end
        // Read data lands in the owner's response register at the end of ACCESS.
        if (state_q == ACCESS) begin
            if (owner_q) begin
                ls_rdata_d = we_q ? 64'd0 : mem_rdata;
            end else begin
                if_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            we_q       <= 1'b0;
            wmask_q    <= 8'd0;
            if_rdata_q <= 64'd0;
            ls_rdata_q <= 64'd0;
        end else begin
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wmask_q    <= wmask_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses queued at stimulus, matched against observed pulses.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_we, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_ce, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0010_0093;
        return {~a[31:0], a[31:0] ^ 32'h1234_5678};
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_we(ls_we), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          cyc;
        logic        ls;
        logic [63:0] a;
        logic [63:0] d;
        logic        we;
        logic [7:0]  m;
    } ev_t;

    typedef struct {
        logic        ls;
        logic [63:0] d;
    } exp_t;

    ev_t  acc_q[$];
    ev_t  ce_q[$];
    ev_t  rsp_q[$];
    exp_t exp_q[$];
    int   cyc;
    int   n_vec;
    int   n_err;
    logic if_rdy_seen;
    logic bus_dirty;

    // Called at a falling edge: sample the cycle's outputs, then advance one cycle.
    task automatic step();
        ev_t e;
        #1;
        e.cyc = cyc; e.ls = 1'b0; e.a = '0; e.d = '0; e.we = 1'b0; e.m = '0;
        if (if_req_ready) if_rdy_seen = 1'b1;
        if (!mem_ce && (mem_we || mem_addr != 0 || mem_wdata != 0 || mem_wmask != 0)) bus_dirty = 1'b1;
        if (if_req_valid && if_req_ready) begin e.ls = 1'b0; e.a = if_addr; acc_q.push_back(e); end
        if (ls_req_valid && ls_req_ready) begin e.ls = 1'b1; e.a = ls_addr; acc_q.push_back(e); end
        if (mem_ce) begin
            e.a = mem_addr; e.d = mem_wdata; e.we = mem_we; e.m = mem_wmask;
            ce_q.push_back(e);
        end
        if (if_resp_valid) begin e.ls = 1'b0; e.d = if_rdata; rsp_q.push_back(e); end
        if (ls_resp_valid) begin e.ls = 1'b1; e.d = ls_rdata; rsp_q.push_back(e); end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        acc_q.delete(); ce_q.delete(); rsp_q.delete();
        if_rdy_seen = 1'b0;
        bus_dirty   = 1'b0;
    endtask

    task automatic issue(input logic ls, input logic [63:0] a, input logic we,
                         input logic [63:0] wd, input logic [7:0] m, output int acc_cyc);
        int   n0;
        exp_t x;
        n0 = acc_q.size();
        if (ls) begin
            ls_req_valid = 1'b1; ls_addr = a; ls_we = we; ls_wdata = wd; ls_wmask = m;
        end else begin
            if_req_valid = 1'b1; if_addr = a;
        end
        x.ls = ls;
        x.d  = (ls && we) ? 64'd0 : mem_model(a);
        exp_q.push_back(x);
        for (int i = 0; i < 10 && acc_q.size() == n0; i++) step();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        n_vec++;
        if (acc_q.size() == n0) begin
            n_err++;
            acc_cyc = -100;
            $display("FAIL accept_timeout: got no accept in 10 cycles, required one");
        end else begin
            acc_cyc = acc_q[$].cyc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #3;
        n_vec++;
        if ({if_req_ready, ls_req_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b, required 00", {if_req_ready, ls_req_ready});
        end
        @(negedge clk); @(negedge clk);
        #1;
        n_vec++;
        if ({if_resp_valid, ls_resp_valid, mem_ce, mem_we} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b, required 0000", {if_resp_valid, ls_resp_valid, mem_ce, mem_we});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, mem_wmask} !== 136'd0) begin
            n_err++; $display("FAIL reset_bus: got %h %h %h, required 0", mem_addr, mem_wdata, mem_wmask);
        end
        n_vec++;
        if ({if_rdata, ls_rdata} !== 128'd0) begin
            n_err++; $display("FAIL reset_rdata: got %h %h, required 0", if_rdata, ls_rdata);
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_fetch();
        int   c;
        ev_t  r;
        exp_t x;
        clear_logs();
        issue(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'd0, c);
        run(4);
        n_vec++;
        if (ce_q.size() !== 1 || ce_q[0].cyc !== c + 1) begin
            n_err++; $display("FAIL fetch_ce_timing: got %0d pulses first at %0d, required 1 at %0d", ce_q.size(), ce_q[0].cyc, c + 1);
        end
        n_vec++;
        if (ce_q[0].a !== 64'h8000_0000 || ce_q[0].we !== 1'b0 || ce_q[0].m !== 8'd0) begin
            n_err++; $display("FAIL fetch_ce_bus: got a=%h we=%b m=%h, required 80000000/0/00", ce_q[0].a, ce_q[0].we, ce_q[0].m);
        end
        n_vec++;
        if (rsp_q.size() !== 1 || rsp_q[0].cyc !== c + 2) begin
            n_err++; $display("FAIL fetch_resp_timing: got %0d at %0d, required 1 at %0d", rsp_q.size(), rsp_q[0].cyc, c + 2);
        end
        n_vec++;
        if (if_rdata !== 64'h0000_0013_0010_0093) begin
            n_err++; $display("FAIL fetch_rdata_hold: got %h, required 0000001300100093", if_rdata);
        end
        n_vec++;
        if (bus_dirty !== 1'b0) begin
            n_err++; $display("FAIL fetch_idle_bus: got nonzero bus outside access, required zero");
        end
        while (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            x = exp_q.pop_front();
            n_vec++;
            if (r.ls !== x.ls || r.d !== x.d) begin
                n_err++; $display("FAIL fetch_sb: got ls=%b d=%h, required ls=%b d=%h", r.ls, r.d, x.ls, x.d);
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL fetch_sb_missing: got %0d undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_store();
        int   c0, c1, c2;
        ev_t  r;
        exp_t x;
        clear_logs();
        issue(1'b1, 64'h8000_2000, 1'b0, 64'h1111, 8'hFF, c0);
        run(3);
        n_vec++;
        if (ls_rdata !== mem_model(64'h8000_2000)) begin
            n_err++; $display("FAIL load_rdata: got %h, required %h", ls_rdata, mem_model(64'h8000_2000));
        end
        issue(1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, c1);
        run(3);
        n_vec++;
        if (ce_q[1].cyc !== c1 + 1 || ce_q[1].we !== 1'b1 || ce_q[1].a !== 64'h8000_1000
            || ce_q[1].d !== 64'hDEAD_BEEF_CAFE_F00D || ce_q[1].m !== 8'h0F) begin
            n_err++; $display("FAIL store_ce: got cyc=%0d we=%b a=%h d=%h m=%h, required cyc=%0d 1/80001000/deadbeefcafef00d/0f",
                              ce_q[1].cyc, ce_q[1].we, ce_q[1].a, ce_q[1].d, ce_q[1].m, c1 + 1);
        end
        n_vec++;
        if (rsp_q[1].cyc !== c1 + 2 || ls_rdata !== 64'd0) begin
            n_err++; $display("FAIL store_resp: got cyc=%0d rdata=%h, required cyc=%0d rdata=0", rsp_q[1].cyc, ls_rdata, c1 + 2);
        end
        issue(1'b1, 64'h8000_1008, 1'b1, 64'h55, 8'h00, c2);
        run(3);
        n_vec++;
        if (ce_q.size() !== 3 || rsp_q.size() !== 3 || ce_q[2].we !== 1'b1 || ce_q[2].m !== 8'h00) begin
            n_err++; $display("FAIL store_zero_mask: got ce=%0d resp=%0d, required 3 and 3", ce_q.size(), rsp_q.size());
        end
        n_vec++;
        if (if_rdata !== 64'h0000_0013_0010_0093) begin
            n_err++; $display("FAIL if_rdata_untouched: got %h, required 0000001300100093", if_rdata);
        end
        while (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            x = exp_q.pop_front();
            n_vec++;
            if (r.ls !== x.ls || r.d !== x.d) begin
                n_err++; $display("FAIL store_sb: got ls=%b d=%h, required ls=%b d=%h", r.ls, r.d, x.ls, x.d);
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL store_sb_missing: got %0d undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] owners;
        int         c0;
        ev_t        r;
        exp_t       x;
`ifdef MEM_ARBITER_RR_EN
        owners = 4'b0101;
`else
        owners = 4'b1111;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        if_addr = 64'h8000_0200; ls_addr = 64'h8000_0300; ls_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x.ls = owners[i];
            x.d  = mem_model(owners[i] ? 64'h8000_0300 : 64'h8000_0200);
            exp_q.push_back(x);
        end
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        c0 = cyc;
        run(12);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        run(3);
        n_vec++;
        if (acc_q.size() !== 4) begin
            n_err++; $display("FAIL arb_count: got %0d accepts, required 4", acc_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (acc_q[i].cyc !== c0 + 3 * i || acc_q[i].ls !== owners[i]) begin
                n_err++; $display("FAIL arb_grant%0d: got cyc=%0d ls=%b, required cyc=%0d ls=%b",
                                  i, acc_q[i].cyc, acc_q[i].ls, c0 + 3 * i, owners[i]);
            end
        end
`ifndef MEM_ARBITER_RR_EN
        n_vec++;
        if (if_rdy_seen !== 1'b0) begin
            n_err++; $display("FAIL arb_if_ready: got if_req_ready=1 under contention, required never");
        end
`endif
        while (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            x = exp_q.pop_front();
            n_vec++;
            if (r.ls !== x.ls || r.d !== x.d) begin
                n_err++; $display("FAIL arb_sb: got ls=%b d=%h, required ls=%b d=%h", r.ls, r.d, x.ls, x.d);
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL arb_sb_missing: got %0d undelivered, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int   c, c2;
        ev_t  r;
        exp_t x;
        clear_logs();
        issue(1'b1, 64'h8000_3000, 1'b0, 64'd0, 8'hFF, c);
        exp_q.pop_back();
        #1;
        n_vec++;
        if (mem_ce !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre_ce: got mem_ce=%b, required 1", mem_ce);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mem_ce, ls_resp_valid, mem_addr, ls_rdata} !== 130'd0) begin
            n_err++; $display("FAIL midrst_force: got ce=%b rv=%b a=%h rd=%h, required all 0", mem_ce, ls_resp_valid, mem_addr, ls_rdata);
        end
        @(negedge clk);
        cyc++;
        run(2);
        rst_n = 1'b1;
        run(3);
        n_vec++;
        if (rsp_q.size() !== 0) begin
            n_err++; $display("FAIL midrst_no_resp: got %0d responses, required 0", rsp_q.size());
        end
        clear_logs();
        issue(1'b1, 64'h8000_4000, 1'b0, 64'd0, 8'hFF, c2);
        run(3);
        n_vec++;
        if (ce_q[0].cyc !== c2 + 1 || rsp_q[0].cyc !== c2 + 2) begin
            n_err++; $display("FAIL midrst_latency: got ce=%0d resp=%0d, required %0d and %0d", ce_q[0].cyc, rsp_q[0].cyc, c2 + 1, c2 + 2);
        end
        while (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            x = exp_q.pop_front();
            n_vec++;
            if (r.ls !== x.ls || r.d !== x.d) begin
                n_err++; $display("FAIL midrst_sb: got ls=%b d=%h, required ls=%b d=%h", r.ls, r.d, x.ls, x.d);
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL midrst_sb_missing: got %0d undelivered, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        ev_t  r;
        exp_t x;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            x.ls = 1'b0;
            x.d  = mem_model(64'h8000_0100);
            exp_q.push_back(x);
        end
        if_addr = 64'h8000_0100;
        if_req_valid = 1'b1;
        run(12);
        if_req_valid = 1'b0;
        run(3);
        n_vec++;
        if (ce_q.size() !== 4 || rsp_q.size() !== 4) begin
            n_err++; $display("FAIL b2b_count: got ce=%0d resp=%0d, required 4 and 4", ce_q.size(), rsp_q.size());
        end
        for (int i = 1; i < 4; i++) begin
            n_vec++;
            if (ce_q[i].cyc - ce_q[i-1].cyc !== 3 || rsp_q[i].cyc - rsp_q[i-1].cyc !== 3) begin
                n_err++; $display("FAIL b2b_spacing%0d: got ce gap %0d resp gap %0d, required 3 and 3",
                                  i, ce_q[i].cyc - ce_q[i-1].cyc, rsp_q[i].cyc - rsp_q[i-1].cyc);
            end
        end
        n_vec++;
        if (bus_dirty !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle_bus: got nonzero bus outside access, required zero");
        end
        while (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            x = exp_q.pop_front();
            n_vec++;
            if (r.ls !== x.ls || r.d !== x.d) begin
                n_err++; $display("FAIL b2b_sb: got ls=%b d=%h, required ls=%b d=%h", r.ls, r.d, x.ls, x.d);
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL b2b_sb_missing: got %0d undelivered, required 0", exp_q.size());
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wdata = '0; ls_we = 1'b0; ls_wmask = '0;
        if_rdy_seen = 1'b0; bus_dirty = 1'b0;
        test_reset();
        test_fetch();
        test_store();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
